// File: rtl/div11x11_pkg.sv
// Shared FP mantissa-path definitions: widths, divider FSM encoding and
// the operand-load helper used by the mantissa divider.
package div11x11_pkg;

  // Stored mantissa width (hidden bit not included).
  localparam int MW = 10;
  // Quotient width: one integer bit plus MW+1 fraction bits.
  localparam int QW = MW + 2;
  // Operand width once the hidden 1 is prepended.
  localparam int OW = MW + 1;
  // Partial-remainder width: two guard bits above the operand.
  localparam int RW = MW + 3;
  // Iteration counter width, enough to count 0..QW-1.
  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Initial partial remainder: dividend with hidden bit and two zero guard bits.
  function automatic logic [RW-1:0] load_rem(input logic [MW-1:0] frac);
    load_rem = {2'b00, 1'b1, frac};
  endfunction

  // Divisor with its hidden bit restored.
  function automatic logic [OW-1:0] load_div(input logic [MW-1:0] frac);
    load_div = {1'b1, frac};
  endfunction

endpackage : div11x11_pkg

// File: rtl/div11x11_div_step.sv
// One restoring-division iteration: compare the partial remainder with the
// divisor and subtract when it fits. The caller applies the left shift.
module div_step
  import div11x11_pkg::*;
(
  input  logic [RW-1:0] r_i,
  input  logic [OW-1:0] d_i,
  output logic          q_o,
  output logic [RW-1:0] rn_o
);

  logic [RW-1:0] d_ext_s;
  logic          ge_s;

  assign d_ext_s = {2'b00, d_i};
  assign ge_s    = (r_i >= d_ext_s);

  // Restore (keep R) when the divisor does not fit, otherwise subtract it.
  always_comb begin
    q_o  = 1'b0;
    rn_o = r_i;
    if (ge_s) begin
      q_o  = 1'b1;
      rn_o = r_i - d_ext_s;
    end else begin
      q_o  = 1'b0;
      rn_o = r_i;
    end
  end

endmodule : div_step

// File: rtl/div11x11.sv
// Sequential restoring mantissa divider. Accepts two stored mantissas on a
// start pulse, runs QW restoring iterations and presents the quotient
// floor({1,f1} * 2^(MW+1) / {1,f2}) with a sticky bit for rounding.
module div11x11
  import div11x11_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          st,
  input  logic [MW-1:0] f1,
  input  logic [MW-1:0] f2,
  output logic          done,
  output logic [QW-1:0] result,
  output logic          sticky,
  output logic          busy
);

  localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

  div_state_e    state_q, state_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [OW-1:0] dvs_q, dvs_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] result_q, result_d;
  logic          sticky_q, sticky_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic          step_q_s;
  logic [RW-1:0] step_rn_s;

  div_step u_div_step (
    .r_i  (rem_q),
    .d_i  (dvs_q),
    .q_o  (step_q_s),
    .rn_o (step_rn_s)
  );

  // State, datapath and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rem_q    <= {RW{1'b0}};
      dvs_q    <= {OW{1'b0}};
      quo_q    <= {QW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      result_q <= {QW{1'b0}};
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and datapath update for the IDLE / ITER / DONE sequence.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    sticky_d = sticky_q;
    done_d   = done_q;
    busy_d   = busy_q;

    case (state_q)
      ST_IDLE: begin
        // Operands are captured only here; the previous result is held
        // until the new operation completes.
        if (st) begin
          rem_d   = load_rem(f1);
          dvs_d   = load_div(f2);
          quo_d   = {QW{1'b0}};
          cnt_d   = {CW{1'b0}};
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_ITER;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ITER: begin
        // Shift the new quotient bit in MSB-first; the remainder after a
        // restore is always below 2*D, so dropping its top bit is lossless.
        quo_d = {quo_q[QW-2:0], step_q_s};
        rem_d = {step_rn_s[RW-2:0], 1'b0};
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ITER;
        end
      end

      ST_DONE: begin
        // Any nonzero leftover remainder means the quotient is inexact.
        result_d = quo_q;
        sticky_d = |rem_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign done   = done_q;
  assign result = result_q;
  assign sticky = sticky_q;
  assign busy   = busy_q;

endmodule : div11x11

// File: tb/tb_div11x11.sv
// Self-checking bench for the mantissa divider: a queue of expected
// {result, sticky} pairs is filled at start and drained on done.
module tb_div11x11;
  import div11x11_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          st;
  logic [MW-1:0] f1, f2;
  logic          done, sticky, busy;
  logic [QW-1:0] result;

  logic [RW-1:0] ds_r;
  logic [OW-1:0] ds_d;
  logic          ds_q;
  logic [RW-1:0] ds_rn;

  int n_vec = 0;
  int n_bad = 0;
  logic [QW:0] sb[$];

  always #5 clk = ~clk;

  div11x11 dut (
    .clk    (clk),
    .reset  (reset),
    .st     (st),
    .f1     (f1),
    .f2     (f2),
    .done   (done),
    .result (result),
    .sticky (sticky),
    .busy   (busy)
  );

  div_step u_step (
    .r_i  (ds_r),
    .d_i  (ds_d),
    .q_o  (ds_q),
    .rn_o (ds_rn)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference quotient and sticky from plain integer arithmetic.
  function automatic logic [QW:0] model(input logic [MW-1:0] a, input logic [MW-1:0] b);
    int unsigned num, den;
    num = (32'd1024 + 32'(a)) * 32'd2048;
    den = 32'd1024 + 32'(b);
    model = {QW'(num / den), (num % den) != 32'd0};
  endfunction

  task automatic start_op(input logic [MW-1:0] a, input logic [MW-1:0] b);
    @(negedge clk);
    f1 = a;
    f2 = b;
    st = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1 st = 1'b0;
  endtask

  // Called right after the accepting edge; expects done 13 cycles later.
  task automatic wait_done(input string tag);
    int cyc;
    bit seen;
    logic [QW:0] e;
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (cyc == 0) begin
        chk({tag, "_busy_run"}, 32'(busy), 32'd1);
        chk({tag, "_done_run"}, 32'(done), 32'd0);
      end
      cyc++;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (seen) begin
        chk({tag, "_lat"}, 32'(cyc), 32'd13);
        chk({tag, "_res"}, 32'(result), 32'(e[QW:1]));
        chk({tag, "_sticky"}, 32'(sticky), 32'(e[0]));
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    logic [MW-1:0] ra, rb;
    logic [QW:0] e;
    reset = 1'b1;
    st    = 1'b0;
    f1    = '0;
    f2    = '0;
    ds_r  = '0;
    ds_d  = 11'h400;

    // Single iteration in isolation, including the R == D boundary.
    for (int i = 0; i < 8; i++) begin
      ds_d = OW'(1024 + $urandom_range(0, 1023));
      ds_r = (i == 0) ? RW'(ds_d) : RW'($urandom_range(0, 4095));
      #1;
      chk("step_q", 32'(ds_q), 32'(ds_r >= RW'(ds_d)));
      chk("step_rn", 32'(ds_rn), (ds_r >= RW'(ds_d)) ? 32'(ds_r - RW'(ds_d)) : 32'(ds_r));
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_sticky", 32'(sticky), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    start_op(10'h000, 10'h000); wait_done("one_one");
    chk("one_one_const", 32'(result), 32'h800);
    start_op(10'h3FF, 10'h000); wait_done("max_q");
    chk("max_q_const", 32'(result), 32'hFFE);
    start_op(10'h000, 10'h3FF); wait_done("min_q");
    chk("min_q_const", 32'(result), 32'h400);
    chk("min_q_sticky_const", 32'(sticky), 32'd1);
    start_op(10'h200, 10'h000); wait_done("c00");
    chk("c00_const", 32'(result), 32'hC00);

    // Outputs hold in IDLE until the next start is accepted.
    repeat (3) @(negedge clk);
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_result", 32'(result), 32'hC00);

    // Start while busy must be ignored entirely.
    start_op(10'h200, 10'h200);
    chk("accept_done_drop", 32'(done), 32'd0);
    chk("accept_result_kept", 32'(result), 32'hC00);
    fork
      begin
        repeat (3) @(negedge clk);
        f1 = 10'h3FF;
        f2 = 10'h000;
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
      end
    join_none
    wait_done("ignore");
    chk("ignore_const", 32'(result), 32'h800);
    repeat (4) @(negedge clk);
    chk("ignore_no_restart", 32'(busy), 32'd0);
    chk("ignore_done_held", 32'(done), 32'd1);
    chk("ignore_result_held", 32'(result), 32'h800);

    for (int i = 0; i < 6; i++) begin
      ra = MW'($urandom_range(0, 1023));
      rb = MW'($urandom_range(0, 1023));
      start_op(ra, rb);
      wait_done("rand");
    end

    // st held high: back-to-back operations with a one-cycle done.
    @(negedge clk);
    f1 = 10'h155;
    f2 = 10'h2AA;
    st = 1'b1;
    sb.push_back(model(10'h155, 10'h2AA));
    sb.push_back(model(10'h155, 10'h2AA));
    @(posedge clk);
    #1;
    wait_done("cont1");
    wait_done("cont2");
    st = 1'b0;

    // Asynchronous reset in the middle of ITER aborts at once.
    start_op(10'h0F0, 10'h321);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sticky", 32'(sticky), 32'd0);
    if (sb.size() > 0) e = sb.pop_front();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_abort_done", 32'(done), 32'd0);
    chk("post_abort_busy", 32'(busy), 32'd0);
    start_op(10'h3FF, 10'h000); wait_done("post_abort");
    chk("post_abort_const", 32'(result), 32'hFFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_div11x11

// File: doc/div11x11.md
Name: div11x11

Overview:
- Sequential restoring divider for the mantissa path of the FP unit; the divide counterpart of the shift-add mantissa multiplier.
- Takes two 10-bit stored mantissas and prepends the hidden 1 to each, giving 11-bit operands.
- Produces a 12-bit quotient with 11 fraction bits, plus a sticky bit for rounding.
- Sits beside the multiplier in the datapath and uses the same st/done handshake.

Parameters:
- MW, 10, stored mantissa width (operand width is MW+1 with the hidden bit).
- QW, 12, quotient width: MW+2 bits (1 integer bit, MW+1 fraction bits).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- st  input  1  start request; sampled only in IDLE
- f1  input  MW  dividend stored mantissa
- f2  input  MW  divisor stored mantissa
- done  output  1  result valid; held high until the next accepted st or reset
- result  output  QW  quotient, floor({1,f1} * 2^(MW+1) / {1,f2})
- sticky  output  1  1 when the final remainder is nonzero
- busy  output  1  high while in ITER

Behaviour:
- Reset (asynchronous, any state): all of the following go to 0 immediately: state=IDLE, done, result, sticky, busy, internal remainder, divisor and counter registers.
- FSM states: IDLE, ITER, DONE.
- IDLE with st=1 at a rising edge:
  - R <= {2'b00, 1, f1} (MW+3 bits); D <= {1, f2}; Q <= 0; cnt <= 0.
  - done <= 0; busy <= 1; go to ITER.
- ITER, each cycle:
  - If R >= D then q=1 and Rn = R - D; else q=0 and Rn = R.
  - Q <= {Q[QW-2:0], q}; R <= Rn << 1; cnt <= cnt + 1.
  - When cnt == QW-1, this is the last step: go to DONE.
  - The compare and subtract are unsigned, MW+3 bits wide.
- DONE (one cycle):
  - result <= Q; sticky <= (R != 0); done <= 1; busy <= 0; go to IDLE.
- Latency: st sampled at edge 0, QW iteration edges (1..QW), done and result valid after edge QW+1, i.e. 13 cycles at default.
- Hold: result, sticky and done stay stable in IDLE until the next st is accepted. On that accepting edge done drops to 0; result keeps its old value until the new DONE.
- st during ITER or DONE is ignored: no queueing, no restart.
- st held high continuously: a new operation starts on each return to IDLE, so done is high for exactly one cycle between operations.
- f1/f2 are sampled only on the accepting edge; later changes have no effect.
- Range: the divisor is never zero (hidden bit), so there is no exception path. The quotient lies in [1024, 4094], so result[QW-1:QW-2] is never 00.
  - result[QW-1]=1 means quotient >= 1.0; otherwise the downstream normaliser shifts left by 1 and decrements the exponent.
- Reset asserted mid-ITER aborts immediately; after release the block is in IDLE with done=0.

Decomposition:
- Shared FP package: MW, QW and the state encodings (IDLE=2'd0, ITER=2'd1, DONE=2'd2).
- Natural sub-module div_step: combinational compare/subtract/shift for one restoring iteration.
  - Inputs: R, D. Outputs: q, Rn.
  - Lets the bench check the iteration in isolation.
- Counter, FSM and output registers stay in div11x11.

Test Plan:
- f1=0x000, f2=0x000, pulse st -> done after 13 cycles; result=0x800 (2048), sticky=0, busy low once done rises.
- f1=0x3FF, f2=0x000 -> result=0xFFE (4094), sticky=0.
- f1=0x000, f2=0x3FF -> result=0x400 (1024), sticky=1; checks the quotient<1 normalisation case.
- f1=0x200, f2=0x000 -> result=0xC00 (3072), sticky=0.
- f1=0x200, f2=0x200 -> result=0x800. Then, while busy, re-pulse st with f1=0x3FF and f2=0x000 -> ignored; the first result stays 0x800 with no extra done.
- Start an operation, assert reset asynchronously at ITER cycle 5 (between clock edges) -> done=0, result=0, busy=0 immediately. After release, start f1=0x3FF, f2=0x000 -> result=0xFFE after 13 cycles.
